enc_16x4_seq: RTL and testbench

Registered 16-to-4 priority encoder with valid/ready handshake and one-hot fault detection. It is the inverse of the 4x16 decoder and closes the loop in decoder fault-injection benches: decoder outputs D feed this block, and the recovered X/Y/Z/W are compared against the stimulus. Non-one-hot words, from stuck-at faults or multi-select, are flagged per word and counted.

---
 rtl/enc_pkg.sv | 23 ++
 rtl/enc_16x4_seq_onehot_check.sv | 22 ++
 rtl/enc_16x4_seq.sv | 124 ++++++++++++
 tb/tb_enc_16x4_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and encode helper
// for the 16-to-4 sequential priority encoder.
package enc_pkg;

  localparam int DEC_N  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [CODE_W-1:0] hsb_idx(
    input logic [DEC_N-1:0] d
  );
    hsb_idx = '0;
    for (int i = 0; i < DEC_N; i++) begin
      if (d[i]) hsb_idx = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/enc_16x4_seq_onehot_check.sv
// Combinational one-hot check: highest-bit code,
// all-zero flag and multiple-bits-set flag.
module onehot_check
  import enc_pkg::*;
(
  input  logic [DEC_N-1:0]  d,
  output logic [CODE_W-1:0] code,
  output logic              zero,
  output logic              multi
);

  logic [DEC_N-1:0] d_m1;

  always_comb begin
    d_m1  = d - DEC_N'(1);
    code  = hsb_idx(d);
    zero  = (d == '0);
    // Clearing the lowest set bit leaves something only if 2+ were set.
    multi = ((d & d_m1) != '0);
  end

endmodule

// File: rtl/enc_16x4_seq.sv
// Registered 16-to-4 priority encoder with valid/ready
// handshake, one-hot fault flags and saturating fault counter.
module enc_16x4_seq
  import enc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             X,
  output logic             Y,
  output logic             Z,
  output logic             W,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault,
  output logic             multi,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             fault_sticky,
  input  logic             clr
);

  state_e state_q, state_d;

  logic [CODE_W-1:0] code_q, code_d;
  logic              fault_q, fault_d;
  logic              multi_q, multi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  logic [CODE_W-1:0] enc_code;
  logic              enc_zero;
  logic              enc_multi;
  logic              enc_fault;
  logic              accept;

  onehot_check u_chk (
    .d     (D),
    .code  (enc_code),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  assign enc_fault = enc_zero | enc_multi;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready never looks at in_valid, so no valid->ready loop.
  always_comb begin
    in_ready  = ~rst & ((state_q == EMPTY) | out_ready);
    out_valid = (state_q == FULL);
  end

  always_comb begin
    code_d  = code_q;
    fault_d = fault_q;
    multi_d = multi_q;
    if (accept) begin
      code_d  = enc_code;
      fault_d = enc_fault;
      multi_d = enc_multi;
    end
  end

  // clr takes priority over a same-cycle faulty accept.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept & enc_fault) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      fault_q  <= 1'b0;
      multi_q  <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      code_q   <= code_d;
      fault_q  <= fault_d;
      multi_q  <= multi_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign X            = code_q[3];
  assign Y            = code_q[2];
  assign Z            = code_q[1];
  assign W            = code_q[0];
  assign fault        = fault_q;
  assign multi        = multi_q;
  assign fault_cnt    = cnt_q;
  assign fault_sticky = sticky_q;

endmodule

// File: tb/tb_enc_16x4_seq.sv
// Scoreboard bench for enc_16x4_seq: reference model,
// random backpressure, decoder loopback, CNT_W=2 saturation.
module tb_enc_16x4_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] D;
  logic        in_valid, in_ready;
  logic        X, Y, Z, W;
  logic        out_valid, out_ready;
  logic        fault, multi;
  logic [7:0]  fault_cnt;
  logic        fault_sticky, clr;

  logic        rst1, v1, clr1, or1;
  logic [15:0] d1;
  logic        ir1, x1, y1, z1, w1, ov1, f1, m1, s1;
  logic [1:0]  cnt1;

  int cmp = 0;
  int mis = 0;
  int pushed = 0;
  int popped = 0;
  int mcnt = 0;
  bit msticky = 0;
  bit rnd_bp = 0;
  logic [5:0] q[$];

  always #5 clk = ~clk;

  enc_16x4_seq #(.CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .D(D), .in_valid(in_valid),
    .in_ready(in_ready), .X(X), .Y(Y), .Z(Z), .W(W),
    .out_valid(out_valid), .out_ready(out_ready),
    .fault(fault), .multi(multi), .fault_cnt(fault_cnt),
    .fault_sticky(fault_sticky), .clr(clr)
  );

  enc_16x4_seq #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst1), .D(d1), .in_valid(v1),
    .in_ready(ir1), .X(x1), .Y(y1), .Z(z1), .W(w1),
    .out_valid(ov1), .out_ready(or1),
    .fault(f1), .multi(m1), .fault_cnt(cnt1),
    .fault_sticky(s1), .clr(clr1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: {code, fault, multi} from counting bits.
  function automatic logic [5:0] ref_enc(input logic [15:0] d);
    int hi;
    int n;
    hi = 0;
    n = $countones(d);
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) begin
        hi = i;
        break;
      end
    end
    return {hi[3:0], n != 1, n > 1};
  endfunction

  function automatic logic [15:0] dec(input int c,
                                      input logic [15:0] sa0);
    logic [15:0] one;
    one = 16'd1;
    return (one << c) & ~sa0;
  endfunction

  // Monitor: output must match queue head while valid; pop on transfer.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("out_word", {28'd0, X, Y, Z, W} << 2 | {fault, multi},
            {26'd0, q[0]});
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [15:0] d);
    logic [5:0] e;
    bit ok;
    e = ref_enc(d);
    D = d;
    in_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        pushed++;
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    if (ok && e[1]) begin
      mcnt = (mcnt == 255) ? 255 : mcnt + 1;
      msticky = 1;
    end
    #1;
    in_valid = 1'b0;
    chk("fault_cnt", fault_cnt, mcnt);
    chk("fault_sticky", fault_sticky, msticky);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; D = 0; in_valid = 0; out_ready = 1; clr = 0;
    rst1 = 1; d1 = 0; v1 = 0; clr1 = 0; or1 = 1;
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code", {X, Y, Z, W}, 0);
    chk("rst_flags", {fault, multi}, 0);
    chk("rst_cnt", fault_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    rst1 = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) send(16'd1 << i);
    idle(2);
    chk("sweep_cnt", fault_cnt, 0);

    send(16'h0000);
    send(16'h8001);
    send(16'h0006);
    idle(2);
    chk("fault3_cnt", fault_cnt, 3);
    chk("fault3_sticky", fault_sticky, 1);

    out_ready = 0;
    send(16'h0040);
    D = 16'h0100;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(16'h0100);
    idle(3);

    rnd_bp = 1;
    for (int n = 0; n < 300; n++) begin
      logic [15:0] r;
      case ($urandom_range(0, 3))
        0: r = 16'd1 << $urandom_range(0, 15);
        1: r = 16'h0000;
        default: r = 16'($urandom);
      endcase
      send(r);
    end
    rnd_bp = 0;
    #1 out_ready = 1;
    idle(3);

    for (int c = 0; c < 16; c++) send(dec(c, 16'h0000));
    send(dec(5, 16'h0020));
    idle(3);

    out_ready = 0;
    send(16'h0800);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    q.delete();
    mcnt = 0;
    msticky = 0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_code", {X, Y, Z, W}, 0);
    chk("rst_mid_flags", {fault, multi}, 0);
    chk("rst_mid_cnt", fault_cnt, 0);
    chk("rst_mid_sticky", fault_sticky, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_mid_ready_after", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    send(16'h0003);
    clr = 1;
    idle(1);
    clr = 0;
    chk("clr_cnt", fault_cnt, 0);
    chk("clr_sticky", fault_sticky, 0);

    d1 = 16'h0000;
    v1 = 1;
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      chk("sat_cnt", cnt1, (k > 3) ? 3 : k);
      chk("sat_out", {ov1, x1, y1, z1, w1, f1, m1}, 7'b1000010);
    end
    clr1 = 1;
    idle(1);
    chk("clr_win_cnt", cnt1, 0);
    chk("clr_win_sticky", s1, 0);
    clr1 = 0;
    idle(1);
    chk("post_clr_cnt", cnt1, 1);
    chk("u1_ready", ir1, 1);
    v1 = 0;

    idle(4);
    chk("queue_empty", q.size(), 0);
    chk("pop_balance", popped, pushed - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
